network_batch_sequencer: RTL and testbench

Sequences a batch of back-to-back inference runs on the `Network` block and buffers each 32-bit result for a downstream consumer. It sits directly upstream and downstream of `Network`: it drives `Network.start`, watches `Network.done`, captures `Network.out` into a small FIFO, and presents results through a valid/ready interface. This replaces hand-driven start/done sequencing with a synthesizable controller.

---
 rtl/network_batch_sequencer.sv | 163 ++++++++++++++++
 tb/tb_network_batch_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/network_batch_sequencer.sv
// Batch controller for the Network block: issues RUNS start/done handshakes and buffers results in a show-ahead FIFO.
// Optional watchdog on the WAIT state is built when NETSEQ_TIMEOUT_EN is defined.
module network_batch_sequencer #(
  parameter int RUNS           = 3,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  output logic        net_start,
  input  logic        net_done,
  input  logic [31:0] net_out,
  output logic        res_valid,
  output logic [31:0] res_data,
  input  logic        res_ready,
  output logic        busy,
  output logic        batch_done,
  output logic [7:0]  run_count,
  output logic        err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0]  RUNS_LAST = 8'(RUNS);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t        state_q;
  logic          done_q;
  logic          done_rise;
  logic          net_start_q;
  logic          batch_done_q;
  logic [7:0]    run_count_q;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop, full;
  logic          timeout_hit;

  assign done_rise = net_done & ~done_q;
  assign full      = (count_q == FULL_CNT);
  assign push      = (state_q == S_WAIT) & done_rise;
  assign pop       = res_valid & res_ready;

  assign net_start  = net_start_q;
  assign res_valid  = (count_q != '0);
  assign res_data   = mem_q[rd_ptr_q];
  assign busy       = (state_q != S_IDLE);
  assign batch_done = batch_done_q;
  assign run_count  = run_count_q;

`ifdef NETSEQ_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_q;
  logic        err_timeout_q;

  // GAP always precedes WAIT, so clearing in GAP is clearing on WAIT entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q <= '0;
    end else if (state_q == S_GAP) begin
      wd_q <= '0;
    end else if (state_q == S_WAIT) begin
      wd_q <= wd_q + 16'd1;
    end
  end

  assign timeout_hit = (state_q == S_WAIT) & (wd_q == WD_LAST) & ~done_rise;
  assign err_timeout = err_timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      done_q       <= 1'b0;
      net_start_q  <= 1'b0;
      batch_done_q <= 1'b0;
      run_count_q  <= '0;
`ifdef NETSEQ_TIMEOUT_EN
      err_timeout_q <= 1'b0;
`endif
    end else begin
      done_q       <= net_done;
      batch_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go) begin
            run_count_q <= '0;
`ifdef NETSEQ_TIMEOUT_EN
            err_timeout_q <= 1'b0;
`endif
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (run_count_q == RUNS_LAST) begin
            batch_done_q <= 1'b1;
            state_q      <= S_IDLE;
          end else if (!full) begin
            net_start_q <= 1'b1;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (done_rise) begin
            net_start_q <= 1'b0;
            run_count_q <= run_count_q + 8'd1;
            state_q     <= S_GAP;
          end else if (timeout_hit) begin
`ifdef NETSEQ_TIMEOUT_EN
            err_timeout_q <= 1'b1;
`endif
            net_start_q  <= 1'b0;
            batch_done_q <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          net_start_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= net_out;
    end
  end

endmodule

// File: tb/tb_network_batch_sequencer.sv
// Directed bench for network_batch_sequencer: three configurations share one stimulus bus; a scoreboard checks pops.
module tb_network_batch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic        net_done;
  logic [31:0] net_out;
  logic        res_ready;

  logic [2:0]  net_start_w, res_valid_w, busy_w, batch_done_w, err_w;
  logic [31:0] res_data_w  [3];
  logic [7:0]  run_count_w [3];

  int          errors = 0;
  int          checks = 0;
  int          sel = 0;
  int          bd_count = 0;
  int          runs_done = 0;
  logic        alt_ready = 1'b0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  network_batch_sequencer #(.RUNS(3), .DEPTH(4), .TIMEOUT_CYCLES(20)) u0 (
    .clk(clk), .reset(reset), .go(go), .net_start(net_start_w[0]), .net_done(net_done),
    .net_out(net_out), .res_valid(res_valid_w[0]), .res_data(res_data_w[0]), .res_ready(res_ready),
    .busy(busy_w[0]), .batch_done(batch_done_w[0]), .run_count(run_count_w[0]), .err_timeout(err_w[0]));

  network_batch_sequencer #(.RUNS(3), .DEPTH(2), .TIMEOUT_CYCLES(20)) u1 (
    .clk(clk), .reset(reset), .go(go), .net_start(net_start_w[1]), .net_done(net_done),
    .net_out(net_out), .res_valid(res_valid_w[1]), .res_data(res_data_w[1]), .res_ready(res_ready),
    .busy(busy_w[1]), .batch_done(batch_done_w[1]), .run_count(run_count_w[1]), .err_timeout(err_w[1]));

  network_batch_sequencer #(.RUNS(5), .DEPTH(2), .TIMEOUT_CYCLES(20)) u2 (
    .clk(clk), .reset(reset), .go(go), .net_start(net_start_w[2]), .net_done(net_done),
    .net_out(net_out), .res_valid(res_valid_w[2]), .res_data(res_data_w[2]), .res_ready(res_ready),
    .busy(busy_w[2]), .batch_done(batch_done_w[2]), .run_count(run_count_w[2]), .err_timeout(err_w[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (alt_ready) res_ready = ~res_ready;
  endtask

  // Pops are judged at the negedge before the edge that performs them.
  always @(negedge clk) begin
    if (batch_done_w[sel]) bd_count++;
    if (res_valid_w[sel] && res_ready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL pop_pending observed=empty_scoreboard expected=pending_result");
      end
      if (exp_q.size() > 0) check("pop_data", res_data_w[sel], exp_q.pop_front());
    end
  end

  task automatic do_reset(input int new_sel);
    alt_ready = 1'b0;
    res_ready = 1'b0;
    go        = 1'b0;
    net_done  = 1'b0;
    reset     = 1'b1;
    sel       = new_sel;
    tick();
    tick();
    exp_q.delete();
    reset     = 1'b0;
    bd_count  = 0;
    runs_done = 0;
    tick();
  endtask

  // Network model: waits for start, returns done one cycle later with val.
  task automatic net_run(input logic [31:0] val);
    int t = 0;
    while (!net_start_w[sel] && t < 200) begin
      tick();
      t++;
    end
    checks++;
    assert (t < 200) else begin
      errors++;
      $error("FAIL start_wait observed=timeout expected=net_start_high");
    end
    tick();
    net_out  = val;
    net_done = 1'b1;
    exp_q.push_back(val);
    runs_done++;
    tick();
    check("start_drop", net_start_w[sel], 1'b0);
    check("run_inc", run_count_w[sel], 32'(runs_done));
    net_done = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset = 1'b1; go = 1'b0; net_done = 1'b0; net_out = '0; res_ready = 1'b0;
    repeat (15) tick();
    check("rst_net_start", net_start_w[0], 1'b0);
    check("rst_res_valid", res_valid_w[0], 1'b0);
    check("rst_res_data", res_data_w[0], 32'h0);
    check("rst_busy", busy_w[0], 1'b0);
    check("rst_batch_done", batch_done_w[0], 1'b0);
    check("rst_run_count", run_count_w[0], 32'h0);
    check("rst_err", err_w[0], 1'b0);
    reset = 1'b0;
    tick();

    // Nominal batch
    res_ready = 1'b1;
    go = 1'b1;
    tick();
    go = 1'b0;
    check("nom_busy", busy_w[0], 1'b1);
    check("nom_start_lat0", net_start_w[0], 1'b0);
    tick();
    check("nom_start_lat1", net_start_w[0], 1'b1);
    net_run(32'h11);
    net_run(32'h22);
    net_run(32'h33);
    check("nom_batch_done", batch_done_w[0], 1'b1);
    check("nom_busy_fall", busy_w[0], 1'b0);
    tick();
    check("nom_batch_done_end", batch_done_w[0], 1'b0);
    repeat (3) tick();
    check("nom_sb_empty", 32'(exp_q.size()), 32'h0);
    check("nom_bd_count", 32'(bd_count), 32'h1);
    check("nom_run_count", run_count_w[0], 32'h3);

    // Edges: done held high across GAP, go while busy
    do_reset(0);
    res_ready = 1'b1;
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tick();
    net_out = 32'hA1; net_done = 1'b1;
    exp_q.push_back(32'hA1);
    runs_done++;
    tick();
    check("edge_first_cap", run_count_w[0], 32'h1);
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tick();
    check("edge_no_dup", run_count_w[0], 32'h1);
    check("edge_waiting", net_start_w[0], 1'b1);
    net_done = 1'b0;
    tick();
    net_run(32'hA2);
    net_run(32'hA3);
    check("edge_batch_done", batch_done_w[0], 1'b1);
    repeat (3) tick();
    check("edge_go_dropped", busy_w[0], 1'b0);
    check("edge_bd_count", 32'(bd_count), 32'h1);
    check("edge_sb_empty", 32'(exp_q.size()), 32'h0);

    // Backpressure on DEPTH=2, RUNS=3
    do_reset(1);
    go = 1'b1;
    tick();
    go = 1'b0;
    net_run(32'h11);
    net_run(32'h22);
    repeat (4) tick();
    check("bp_stall_start", net_start_w[1], 1'b0);
    check("bp_stall_busy", busy_w[1], 1'b1);
    check("bp_stall_valid", res_valid_w[1], 1'b1);
    check("bp_stall_runs", run_count_w[1], 32'h2);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp_no_same_edge", net_start_w[1], 1'b0);
    tick();
    check("bp_resume", net_start_w[1], 1'b1);
    net_run(32'h33);
    check("bp_batch_done", batch_done_w[1], 1'b1);
    res_ready = 1'b1;
    repeat (4) tick();
    check("bp_sb_empty", 32'(exp_q.size()), 32'h0);
    check("bp_drained", res_valid_w[1], 1'b0);

    // Wrap-around on DEPTH=2, RUNS=5 with alternating ready
    do_reset(2);
    alt_ready = 1'b1;
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 1; i <= 5; i++) net_run(32'(i));
    check("wrap_batch_done", batch_done_w[2], 1'b1);
    alt_ready = 1'b0;
    res_ready = 1'b1;
    repeat (5) tick();
    check("wrap_sb_empty", 32'(exp_q.size()), 32'h0);
    check("wrap_run_count", run_count_w[2], 32'h5);
    check("wrap_bd_count", 32'(bd_count), 32'h1);

    // Reset during WAIT after one capture
    do_reset(0);
    go = 1'b1;
    tick();
    go = 1'b0;
    net_run(32'h55);
    check("mid_valid", res_valid_w[0], 1'b1);
    check("mid_waiting", net_start_w[0], 1'b1);
    reset = 1'b1;
    tick();
    exp_q.delete();
    check("mid_rst_start", net_start_w[0], 1'b0);
    check("mid_rst_valid", res_valid_w[0], 1'b0);
    check("mid_rst_runs", run_count_w[0], 32'h0);
    check("mid_rst_busy", busy_w[0], 1'b0);
    reset = 1'b0;
    tick();

    // Watchdog
    do_reset(0);
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
`ifdef NETSEQ_TIMEOUT_EN
    repeat (19) tick();
    check("wd_before_err", err_w[0], 1'b0);
    check("wd_before_busy", busy_w[0], 1'b1);
    tick();
    check("wd_err", err_w[0], 1'b1);
    check("wd_batch_done", batch_done_w[0], 1'b1);
    check("wd_start_drop", net_start_w[0], 1'b0);
    check("wd_busy_fall", busy_w[0], 1'b0);
    tick();
    check("wd_pulse_end", batch_done_w[0], 1'b0);
    check("wd_sticky", err_w[0], 1'b1);
    check("wd_bd_count", 32'(bd_count), 32'h1);
    go = 1'b1;
    tick();
    go = 1'b0;
    check("wd_go_clears", err_w[0], 1'b0);
`else
    repeat (40) tick();
    check("nowd_err", err_w[0], 1'b0);
    check("nowd_busy", busy_w[0], 1'b1);
    check("nowd_start", net_start_w[0], 1'b1);
`endif
    do_reset(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
